// File: rtl/lsu_arb_pkg.sv
// Shared types and sizes for the LSU bus arbiter.
package lsu_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BMASK_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [BMASK_W-1:0] bmask;
    logic               wren;
  } lsu_req_t;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

endpackage

// File: rtl/lsu_arb_pick.sv
// Grant selection for the two LSU requesters: round-robin pointer, P1 wait counter,
// and (with LSU_ARB_LOCK_EN defined) a lock owner that excludes the other port.
module lsu_arb_pick
  import lsu_arb_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] valid,
`ifdef LSU_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0] lock,
`endif
  output logic [NUM_PORTS-1:0] grant_c
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  port_e                rr_ptr;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 locked_c;
  logic                 prefer_p1_c;
  logic [NUM_PORTS-1:0] elig_c;

`ifdef LSU_ARB_LOCK_EN
  logic  lock_held;
  port_e owner;

  assign locked_c = lock_held;

  // While a lock is held only the owner may be granted.
  always_comb begin
    elig_c = valid;
    if (lock_held) begin
      if (owner == PORT0) elig_c[1] = 1'b0;
      else                elig_c[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_held <= 1'b0;
      owner     <= PORT0;
    end else if (grant_c[0]) begin
      lock_held <= lock[0];
      owner     <= PORT0;
    end else if (grant_c[1]) begin
      lock_held <= lock[1];
      owner     <= PORT1;
    end
  end
`else
  assign locked_c = 1'b0;
  assign elig_c   = valid;
`endif

  // Conflict resolution: RR pointer, or fixed P0 priority with forced P1 after starvation.
  always_comb begin
    prefer_p1_c = RR_EN ? (rr_ptr == PORT1) : ((wait_cnt >= WAIT_LIM) && !locked_c);
    grant_c     = elig_c;
    if (&elig_c) grant_c = {prefer_p1_c, !prefer_p1_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= PORT0;
      wait_cnt <= '0;
    end else begin
      if (|grant_c) rr_ptr <= grant_c[1] ? PORT0 : PORT1;
      if (grant_c[1])                          wait_cnt <= '0;
      else if (valid[1] && wait_cnt < WAIT_LIM) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Shares one LSU port between P0 (MEM stage) and P1 (aux master): registered issue stage
// and tagged response stage. Define LSU_ARB_LOCK_EN to add per-port lock inputs.
module lsu_bus_arbiter
  import lsu_arb_pkg::*;
#(
  parameter bit          RR_EN_DEFAULT = 1'b1,
  parameter int unsigned MAX_WAIT      = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_p0_valid,
  output logic               o_p0_ready,
  input  logic [ADDR_W-1:0]  i_p0_addr,
  input  logic [DATA_W-1:0]  i_p0_wdata,
  input  logic [BMASK_W-1:0] i_p0_bmask,
  input  logic               i_p0_wren,
  output logic               o_p0_rsp_valid,
  output logic [DATA_W-1:0]  o_p0_rsp_rdata,
  input  logic               i_p1_valid,
  output logic               o_p1_ready,
  input  logic [ADDR_W-1:0]  i_p1_addr,
  input  logic [DATA_W-1:0]  i_p1_wdata,
  input  logic [BMASK_W-1:0] i_p1_bmask,
  input  logic               i_p1_wren,
  output logic               o_p1_rsp_valid,
  output logic [DATA_W-1:0]  o_p1_rsp_rdata,
`ifdef LSU_ARB_LOCK_EN
  input  logic               i_p0_lock,
  input  logic               i_p1_lock,
`endif
  output logic [ADDR_W-1:0]  o_lsu_addr,
  output logic [DATA_W-1:0]  o_lsu_wdata,
  output logic [BMASK_W-1:0] o_lsu_bmask,
  output logic               o_lsu_wren,
  input  logic [DATA_W-1:0]  i_lsu_rdata
);

  logic [NUM_PORTS-1:0] grant_c;
  lsu_req_t             req0_c, req1_c, sel_c;
  logic [DATA_W-1:0]    rsp_data_c;
  logic                 iss_valid;
  port_e                iss_port;

  lsu_arb_pick #(
    .RR_EN    (RR_EN_DEFAULT),
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .valid   ({i_p1_valid, i_p0_valid}),
`ifdef LSU_ARB_LOCK_EN
    .lock    ({i_p1_lock, i_p0_lock}),
`endif
    .grant_c (grant_c)
  );

  assign o_p0_ready = grant_c[0];
  assign o_p1_ready = grant_c[1];

  always_comb begin
    req0_c = '{addr: i_p0_addr, wdata: i_p0_wdata, bmask: i_p0_bmask, wren: i_p0_wren};
    req1_c = '{addr: i_p1_addr, wdata: i_p1_wdata, bmask: i_p1_bmask, wren: i_p1_wren};
    sel_c  = grant_c[1] ? req1_c : req0_c;
  end

  // Stores return zero; loads return what the LSU presents during the issue cycle.
  assign rsp_data_c = o_lsu_wren ? '0 : i_lsu_rdata;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      iss_valid   <= 1'b0;
      iss_port    <= PORT0;
      o_lsu_addr  <= '0;
      o_lsu_wdata <= '0;
      o_lsu_bmask <= '0;
      o_lsu_wren  <= 1'b0;
    end else begin
      iss_valid  <= |grant_c;
      o_lsu_wren <= (|grant_c) && sel_c.wren;
      if (|grant_c) begin
        iss_port    <= grant_c[1] ? PORT1 : PORT0;
        o_lsu_addr  <= sel_c.addr;
        o_lsu_wdata <= sel_c.wdata;
        o_lsu_bmask <= sel_c.bmask;
      end
    end
  end

  // Response demux back to the port that owned the issue slot.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_p0_rsp_valid <= 1'b0;
      o_p0_rsp_rdata <= '0;
      o_p1_rsp_valid <= 1'b0;
      o_p1_rsp_rdata <= '0;
    end else begin
      o_p0_rsp_valid <= iss_valid && (iss_port == PORT0);
      o_p1_rsp_valid <= iss_valid && (iss_port == PORT1);
      o_p0_rsp_rdata <= (iss_valid && (iss_port == PORT0)) ? rsp_data_c : '0;
      o_p1_rsp_rdata <= (iss_valid && (iss_port == PORT1)) ? rsp_data_c : '0;
    end
  end

endmodule
